// File: rtl/clk_lock_supervisor_if.sv
// Status/control bundle between the clock-lock supervisor and its surroundings.
// The supervisor side uses the slave modport; the environment drives through master.
interface clk_lock_supervisor_if;
    logic       locked_async;
    logic       clear_count;
    logic       mmcm_reset;
    logic       rst_out_n;
    logic       ready;
    logic [7:0] lock_loss_count;

    modport master (
        output locked_async, clear_count,
        input  mmcm_reset, rst_out_n, ready, lock_loss_count
    );

    modport slave (
        input  locked_async, clear_count,
        output mmcm_reset, rst_out_n, ready, lock_loss_count
    );
endinterface

// File: rtl/clk_lock_supervisor.sv
// Supervises a clock generator: pulses its reset, waits for a stretched lock, then releases downstream reset.
// Optional lock-loss counter is built only when CLK_LOCK_SUPERVISOR_STATUS_EN is defined.
module clk_lock_supervisor #(
    parameter int PULSE_CYCLES   = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    clk_lock_supervisor_if.slave  bus
);

    localparam int MAX_AB = (PULSE_CYCLES > STRETCH_CYCLES) ? PULSE_CYCLES : STRETCH_CYCLES;
    localparam int MAX_C  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int TW     = $clog2(MAX_C);

    localparam logic [TW-1:0] PULSE_LAST   = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] STRETCH_LAST = TW'(STRETCH_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        MMCM_RST,
        WAIT_LOCK,
        STRETCH,
        RUN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic          w_inc;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_mmcm_reset;
    logic          r_rst_out_n;
    logic          r_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.locked_async;
            r_sync2 <= r_sync1;
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= MMCM_RST;
            r_timer      <= '0;
            r_mmcm_reset <= 1'b1;
            r_rst_out_n  <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_mmcm_reset <= (w_state_nxt == MMCM_RST);
            r_rst_out_n  <= (w_state_nxt == RUN);
            r_ready      <= (w_state_nxt == RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + 1'b1;
        w_inc       = 1'b0;
        case (r_state)
            MMCM_RST: begin
                if (r_timer == PULSE_LAST) begin
                    w_state_nxt = WAIT_LOCK;
                    w_timer_nxt = '0;
                end
            end
            WAIT_LOCK: begin
                if (r_sync2) begin
                    w_state_nxt = STRETCH;
                    w_timer_nxt = '0;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_inc       = 1'b1;
                    w_state_nxt = MMCM_RST;
                    w_timer_nxt = '0;
                end
            end
            STRETCH: begin
                if (!r_sync2) begin
                    w_state_nxt = WAIT_LOCK;
                    w_timer_nxt = '0;
                end else if (r_timer == STRETCH_LAST) begin
                    w_state_nxt = RUN;
                    w_timer_nxt = '0;
                end
            end
            RUN: begin
                w_timer_nxt = '0;
                if (!r_sync2) begin
                    w_inc       = 1'b1;
                    w_state_nxt = MMCM_RST;
                end
            end
            default: begin
                w_state_nxt = MMCM_RST;
                w_timer_nxt = '0;
            end
        endcase
    end

    assign bus.mmcm_reset = r_mmcm_reset;
    assign bus.rst_out_n  = r_rst_out_n;
    assign bus.ready      = r_ready;

`ifdef CLK_LOCK_SUPERVISOR_STATUS_EN
    logic [7:0] r_count;

    // Clear has priority over an increment landing on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 8'd0;
        end else if (bus.clear_count) begin
            r_count <= 8'd0;
        end else if (w_inc && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign bus.lock_loss_count = r_count;
`else
    logic w_unused_status;

    assign w_unused_status     = bus.clear_count ^ w_inc;
    assign bus.lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_clk_lock_supervisor.sv
// Directed bench for clk_lock_supervisor with default parameters; expected output tuples
// are queued as each step is driven and compared against the DUT once the step's edge has passed.
module tb_clk_lock_supervisor;

    logic clk = 1'b0;
    logic reset_n;

    clk_lock_supervisor_if bus();

    clk_lock_supervisor dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [10:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   losses   = 0;

    function automatic logic [7:0] exp_cnt(input int n);
        logic [7:0] r;
        r = (n > 255) ? 8'd255 : 8'(n);
`ifndef CLK_LOCK_SUPERVISOR_STATUS_EN
        r = 8'd0;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input bit m, input bit rdy, input int cnt);
        exp_t e;
        e.tag = tag;
        e.exp = {m, rdy, rdy, exp_cnt(cnt)};
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [10:0] obs;
        obs = {bus.mmcm_reset, bus.rst_out_n, bus.ready, bus.lock_loss_count};
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed mmcm/rst_n/rdy/cnt=%b/%b/%b/%0d required %b/%b/%b/%0d",
                       e.tag, obs[10], obs[9], obs[8], obs[7:0],
                       e.exp[10], e.exp[9], e.exp[8], e.exp[7:0]);
            end
        end
    endtask

    task automatic tick_expect(input string tag, input bit m, input bit rdy, input int cnt);
        tick();
        push(tag, m, rdy, cnt);
        check_sb();
    endtask

    task automatic wait_ready(input bit want, input int limit, input string tag);
        int n;
        n = 0;
        while ((bus.ready !== want) && (n < limit)) begin
            tick();
            n++;
        end
        n_checks++;
        assert (bus.ready === want) else begin
            n_fail++;
            $error("FAIL %s: ready observed %b after %0d cycles, required %b", tag, bus.ready, n, want);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n          = 1'b0;
        bus.locked_async = 1'b0;
        bus.clear_count  = 1'b0;
        repeat (3) tick();
        push("reset", 1'b1, 1'b0, 0);
        check_sb();

        // Release; four edges of generator reset pulse follow.
        reset_n = 1'b1;
        push("release", 1'b1, 1'b0, 0);
        check_sb();
        for (int i = 1; i <= 4; i++) tick_expect("pulse", i < 4, 1'b0, 0);
        for (int i = 1; i <= 10; i++) tick_expect("wait_lock", 1'b0, 1'b0, 0);

        // Lock rises: 2 synchroniser edges, 1 edge for WAIT_LOCK to see it, 16 stretch edges.
        bus.locked_async = 1'b1;
        for (int i = 1; i <= 19; i++) tick_expect("first_run", 1'b0, i == 19, 0);

        // Three-cycle lock drop in RUN, then the full restart sequence.
        bus.locked_async = 1'b0;
        for (int i = 1; i <= 3; i++) tick_expect("run_drop", i == 3, i < 3, (i < 3) ? 0 : 1);
        bus.locked_async = 1'b1;
        for (int i = 4; i <= 24; i++) tick_expect("recover", (i <= 6), (i >= 24), 1);
        losses = 1;

        // Second loss, then lock drops at the eighth STRETCH cycle.
        bus.locked_async = 1'b0;
        for (int i = 1; i <= 3; i++) tick_expect("loss2", i == 3, i < 3, (i < 3) ? 1 : 2);
        losses = 2;
        bus.locked_async = 1'b1;
        for (int i = 4; i <= 15; i++) tick_expect("to_stretch", (i <= 6), 1'b0, losses);
        bus.locked_async = 1'b0;
        for (int i = 16; i <= 18; i++) tick_expect("stretch_drop", 1'b0, 1'b0, losses);
        bus.locked_async = 1'b1;
        for (int i = 19; i <= 37; i++) tick_expect("stretch_restart", 1'b0, (i >= 37), losses);

        // Sub-cycle glitch between edges is never sampled.
        bus.locked_async = 1'b0;
        #3;
        bus.locked_async = 1'b1;
        for (int i = 1; i <= 5; i++) tick_expect("glitch", 1'b0, 1'b1, losses);

        // Reset mid-RUN must act without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        push("async_reset", 1'b1, 1'b0, 0);
        check_sb();
        bus.locked_async = 1'b0;
        repeat (2) tick();

        // Lock held low: restart every 4+1024 cycles, counter steps per timeout.
        reset_n = 1'b1;
        for (int i = 1; i <= 3100; i++)
            tick_expect("timeout", (i <= 3) || ((i >= 1028) && ((i % 1028) < 4)), 1'b0, i / 1028);
        losses = 3;

        // Drive enough losses to saturate the counter.
        while (losses < 299) begin
            bus.locked_async = 1'b1;
            wait_ready(1'b1, 60, "lock_up");
            bus.locked_async = 1'b0;
            wait_ready(1'b0, 6, "lock_down");
            losses++;
            push("loss_count", 1'b1, 1'b0, losses);
            check_sb();
        end

        // Clear lands on the same edge as another loss.
        bus.locked_async = 1'b1;
        wait_ready(1'b1, 60, "relock");
        bus.locked_async = 1'b0;
        tick_expect("sat_hold", 1'b0, 1'b1, losses);
        tick_expect("sat_hold", 1'b0, 1'b1, losses);
        bus.clear_count = 1'b1;
        tick_expect("clear_wins", 1'b1, 1'b0, 0);
        bus.clear_count = 1'b0;
        losses = 0;

        bus.locked_async = 1'b1;
        wait_ready(1'b1, 60, "relock2");
        bus.locked_async = 1'b0;
        wait_ready(1'b0, 6, "drop_after_clear");
        losses = 1;
        push("count_after_clear", 1'b1, 1'b0, losses);
        check_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
